// File: rtl/lc4_div_seq.sv
// LC4 DIV/MOD sequencer: restoring divide, one quotient bit per clock on a shared cla16.
// Optional LC4_DIV_ZERO_FAST_EN: divisor==0 skips BUSY and completes right after accept.

module cla16 (
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  input  logic        cin_i,
  output logic [15:0] sum_o
);

  logic [15:0] g;
  logic [15:0] p;
  logic [15:0] c;
  logic [3:0]  gg;
  logic [3:0]  gp;
  logic [4:0]  gc;

  assign g = a_i & b_i;
  assign p = a_i ^ b_i;

  always_comb begin
    gg = '0;
    gp = '0;
    gc = '0;
    c  = '0;
    for (int k = 0; k < 4; k++) begin
      gg[k] = g[4*k+3]
            | (p[4*k+3] & g[4*k+2])
            | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      gp[k] = &p[4*k +: 4];
    end
    gc[0] = cin_i;
    for (int k = 0; k < 4; k++)
      gc[k+1] = gg[k] | (gp[k] & gc[k]);
    for (int k = 0; k < 4; k++) begin
      c[4*k] = gc[k];
      for (int i = 0; i < 3; i++)
        c[4*k+i+1] = g[4*k+i] | (p[4*k+i] & c[4*k+i]);
    end
  end

  assign sum_o = p ^ c;

endmodule

module lc4_div_seq #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] q_q, q_d;
  logic [DATA_W-1:0] d_q, d_d;
  logic [DATA_W:0]   r_q, r_d;

  logic [DATA_W:0]   rs;
  logic [DATA_W-1:0] s;
  logic [DATA_W-1:0] nd;
  logic              cout;
  logic              ge;

  assign rs = {r_q[DATA_W-1:0], q_q[DATA_W-1]};
  assign nd = ~d_q;

  cla16 u_cla (
    .a_i   (rs[DATA_W-1:0]),
    .b_i   (nd),
    .cin_i (1'b1),
    .sum_o (s)
  );

  // Carry out of bit 15 rebuilt from the sum bit, since cla16 does not export it.
  assign cout = (rs[DATA_W-1] & nd[DATA_W-1])
              | ((rs[DATA_W-1] ^ nd[DATA_W-1]) & ~s[DATA_W-1]);
  assign ge   = rs[DATA_W] | cout;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    d_d     = d_q;
    r_d     = r_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          q_d     = dividend;
          d_d     = divisor;
          r_d     = '0;
          cnt_d   = CNT_W'(DATA_W);
          state_d = BUSY;
`ifdef LC4_DIV_ZERO_FAST_EN
          if (divisor == '0) begin
            q_d     = '0;
            cnt_d   = '0;
            state_d = DONE;
          end
`else
`endif
        end
      end
      BUSY: begin
        r_d   = ge ? {1'b0, s} : rs;
        q_d   = {q_q[DATA_W-2:0], ge};
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
          // LC4 defines x/0 as 0 remainder 0
          if (d_q == '0) begin
            q_d = '0;
            r_d = '0;
          end
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      q_q     <= '0;
      d_q     <= '0;
      r_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      d_q     <= d_d;
      r_q     <= r_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign quotient  = q_q;
  assign remainder = r_q[DATA_W-1:0];

endmodule

// File: tb/tb_lc4_div_seq.sv
// Directed bench for lc4_div_seq: results, latency, hold, busy-ignore, reset abort.

module tb_lc4_div_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] dividend;
  logic [15:0] divisor;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] quotient;
  logic [15:0] remainder;

  int checks;
  int errors;
  int lat;

  lc4_div_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef LC4_DIV_ZERO_FAST_EN
  localparam int ZLAT = 0;
`else
  localparam int ZLAT = 16;
`endif

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    chk("in_ready_before_send", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int exp_lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk(tag, 32'(lat), 32'(exp_lat));
  endtask

  task automatic result(input string tag, input logic [15:0] eq,
                        input logic [15:0] er);
    chk({tag, "_q"}, 32'(quotient), 32'(eq));
    chk({tag, "_r"}, 32'(remainder), 32'(er));
  endtask

  task automatic retire();
    @(posedge clk);
    #1;
    chk("retire_out_valid", 32'(out_valid), 32'd0);
    chk("retire_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    dividend  = '0;
    divisor   = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    result("rst", 16'h0000, 16'h0000);

    send(16'd100, 16'd7);
    wait_done("lat_100_7", 16);
    result("d100_7", 16'd14, 16'd2);
    retire();

    send(16'hFFFF, 16'h8001);
    wait_done("lat_ffff_8001", 16);
    result("dffff_8001", 16'h0001, 16'h7FFE);
    retire();

    send(16'h8000, 16'hFFFF);
    wait_done("lat_8000_ffff", 16);
    result("d8000_ffff", 16'h0000, 16'h8000);
    retire();

    send(16'hFFFF, 16'h0001);
    wait_done("lat_ffff_1", 16);
    result("dffff_1", 16'hFFFF, 16'h0000);
    retire();

    send(16'd5, 16'd0);
    wait_done("lat_div0", ZLAT);
    result("d5_0", 16'h0000, 16'h0000);
    retire();

    out_ready = 1'b0;
    send(16'd1234, 16'd100);
    wait_done("lat_hold", 16);
    for (int i = 0; i < 5; i++) begin
      result("hold", 16'd12, 16'd34);
      chk("hold_out_valid", 32'(out_valid), 32'd1);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    out_ready = 1'b1;
    retire();

    send(16'd1000, 16'd33);
    repeat (3) @(posedge clk);
    @(negedge clk);
    in_valid = 1'b1;
    dividend = 16'd7;
    divisor  = 16'd2;
    @(negedge clk);
    in_valid = 1'b0;
    dividend = 16'd9999;
    divisor  = 16'd1;
    wait_done("lat_busy_ignore", 12);
    result("busy_ignore", 16'd30, 16'd10);
    retire();

    send(16'd50000, 16'd3);
    repeat (7) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    result("abort", 16'h0000, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) lat++;
    end
    chk("abort_no_pulse", 32'(lat), 32'd0);
    send(16'd9, 16'd3);
    wait_done("lat_9_3", 16);
    result("d9_3", 16'd3, 16'd0);
    retire();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
